// File: rtl/rdiv_n_by_n.sv
// rdiv_n_by_n: fixed-latency radix-2 restoring divider (RISC-V DIV/DIVU/REM/REMU).
// Normal operations finish N+1 edges after the accept edge. Divide-by-zero and
// signed overflow finish on the accept edge itself.
// Ports:
//   clk_100, reset      clock, synchronous active-high reset
//   is_signed           two's-complement (1) or unsigned (0), sampled at accept
//   start / done        level handshake; start held until done seen, done held until start drops
//   dividend, divisor   operands, sampled at accept
//   quotient, remainder results, valid while done, held until the next accept
//   div_by_0_err        divisor was zero
//   overflow_err        signed most-negative / -1
module rdiv_n_by_n #(
    parameter int unsigned N = 32
) (
    input  logic         clk_100,
    input  logic         reset,
    input  logic         is_signed,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_0_err,
    output logic         overflow_err
);

    localparam int unsigned CW = $clog2(N + 1);
    localparam logic [N-1:0] MIN_NEG  = {1'b1, {(N-1){1'b0}}};
    localparam logic [N-1:0] ALL_ONES = {N{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_ITER,
        S_FIX,
        S_DONE
    } state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   rem_q, rem_d;       // partial remainder; always < divisor so N bits suffice
    logic [N-1:0]   quo_q, quo_d;       // quotient shift register, starts as |dividend|
    logic [N-1:0]   dvsr_q, dvsr_d;     // |divisor|
    logic           a_neg_q, a_neg_d;   // signed op with negative dividend
    logic           b_neg_q, b_neg_d;   // signed op with negative divisor
    logic           done_q, done_d;
    logic [N-1:0]   quotient_q, quotient_d;
    logic [N-1:0]   remainder_q, remainder_d;
    logic           dbz_q, dbz_d;
    logic           ovf_q, ovf_d;

    logic [N-1:0]   a_mag_c, b_mag_c;
    logic [N:0]     shift_rem_c, trial_c;

    // Operand magnitudes; the most-negative value maps to its unsigned magnitude.
    always_comb begin
        a_mag_c = dividend;
        b_mag_c = divisor;
        if (is_signed && dividend[N-1]) a_mag_c = ~dividend + N'(1);
        if (is_signed && divisor[N-1])  b_mag_c = ~divisor + N'(1);
    end

    // One restoring step: shift in the next dividend bit and trial-subtract at N+1 bits.
    always_comb begin
        shift_rem_c = {rem_q, quo_q[N-1]};
        trial_c     = shift_rem_c - {1'b0, dvsr_q};
    end

    // Next-state and datapath control.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvsr_d      = dvsr_q;
        a_neg_d     = a_neg_q;
        b_neg_d     = b_neg_q;
        done_d      = done_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        ovf_d       = ovf_q;

        case (state_q)
            S_IDLE: begin
                done_d = 1'b0;
                if (start) begin
                    if (divisor == '0) begin
                        quotient_d  = ALL_ONES;
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                        ovf_d       = 1'b0;
                        done_d      = 1'b1;
                        state_d     = S_DONE;
                    end else if (is_signed && dividend == MIN_NEG && divisor == ALL_ONES) begin
                        quotient_d  = dividend;
                        remainder_d = '0;
                        dbz_d       = 1'b0;
                        ovf_d       = 1'b1;
                        done_d      = 1'b1;
                        state_d     = S_DONE;
                    end else begin
                        rem_d   = '0;
                        quo_d   = a_mag_c;
                        dvsr_d  = b_mag_c;
                        a_neg_d = is_signed & dividend[N-1];
                        b_neg_d = is_signed & divisor[N-1];
                        cnt_d   = '0;
                        state_d = S_ITER;
                    end
                end
            end

            S_ITER: begin
                if (!start) begin
                    state_d = S_IDLE;
                end else begin
                    if (!trial_c[N]) begin
                        rem_d = trial_c[N-1:0];
                        quo_d = {quo_q[N-2:0], 1'b1};
                    end else begin
                        rem_d = shift_rem_c[N-1:0];
                        quo_d = {quo_q[N-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(N - 1)) state_d = S_FIX;
                end
            end

            S_FIX: begin
                if (!start) begin
                    state_d = S_IDLE;
                end else begin
                    // Truncating division: remainder takes the dividend's sign.
                    quotient_d  = (a_neg_q ^ b_neg_q) ? (~quo_q + N'(1)) : quo_q;
                    remainder_d = a_neg_q ? (~rem_q + N'(1)) : rem_q;
                    dbz_d       = 1'b0;
                    ovf_d       = 1'b0;
                    done_d      = 1'b1;
                    state_d     = S_DONE;
                end
            end

            S_DONE: begin
                if (!start) begin
                    done_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end

            default: begin
                done_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and result registers.
    always_ff @(posedge clk_100) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvsr_q      <= '0;
            a_neg_q     <= 1'b0;
            b_neg_q     <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvsr_q      <= dvsr_d;
            a_neg_q     <= a_neg_d;
            b_neg_q     <= b_neg_d;
            done_q      <= done_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            ovf_q       <= ovf_d;
        end
    end

    assign done         = done_q;
    assign quotient     = quotient_q;
    assign remainder    = remainder_q;
    assign div_by_0_err = dbz_q;
    assign overflow_err = ovf_q;

endmodule

// File: tb/tb_rdiv_n_by_n.sv
// tb_rdiv_n_by_n: directed vector table, multi-cycle corner sequences and a
// randomized sweep against a truncating-division reference model.
module tb_rdiv_n_by_n;

    localparam int unsigned N = 32;
    localparam int NORM_LAT = N + 1;   // edges after the accept edge until done is seen

    logic         clk_100 = 1'b0;
    logic         reset = 1'b1;
    logic         is_signed = 1'b0;
    logic         start = 1'b0;
    logic [N-1:0] dividend = '0;
    logic [N-1:0] divisor = '0;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_0_err;
    logic         overflow_err;

    int passed = 0;
    int total  = 0;

    rdiv_n_by_n #(.N(N)) dut (
        .clk_100      (clk_100),
        .reset        (reset),
        .is_signed    (is_signed),
        .start        (start),
        .dividend     (dividend),
        .divisor      (divisor),
        .done         (done),
        .quotient     (quotient),
        .remainder    (remainder),
        .div_by_0_err (div_by_0_err),
        .overflow_err (overflow_err)
    );

    always #5 clk_100 = ~clk_100;

    typedef struct {
        logic         s;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         dbz;
        logic         ovf;
        int           lat;
    } vec_t;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // Issues one request, reports latency and results, then completes the handshake.
    task automatic run_op(input logic s, input logic [N-1:0] a, input logic [N-1:0] b,
                          output logic [N-1:0] q, output logic [N-1:0] r,
                          output logic dbz, output logic ovf, output int lat,
                          output logic done_after, output logic [N-1:0] q_after);
        @(negedge clk_100);
        is_signed = s;
        dividend  = a;
        divisor   = b;
        start     = 1'b1;
        @(posedge clk_100);
        #1;
        // Scramble operands after accept; the DUT must ignore them.
        is_signed = ~s;
        dividend  = $urandom;
        divisor   = $urandom;
        lat = 0;
        while (!done && lat < 80) begin
            @(posedge clk_100);
            #1;
            lat++;
        end
        if (!done) check("done_timeout", 64'd0, 64'd1);
        q   = quotient;
        r   = remainder;
        dbz = div_by_0_err;
        ovf = overflow_err;
        @(negedge clk_100);
        start = 1'b0;
        @(posedge clk_100);
        #1;
        done_after = done;
        q_after    = quotient;
    endtask

    function automatic void ref_div(input logic s, input logic [N-1:0] a, input logic [N-1:0] b,
                                    output logic [N-1:0] q, output logic [N-1:0] r,
                                    output logic dbz, output logic ovf);
        logic signed [N-1:0] sa;
        logic signed [N-1:0] sb;
        sa  = a;
        sb  = b;
        dbz = 1'b0;
        ovf = 1'b0;
        if (b == '0) begin
            q = '1; r = a; dbz = 1'b1;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a; r = '0; ovf = 1'b1;
        end else if (s) begin
            q = sa / sb; r = sa % sb;
        end else begin
            q = a / b; r = a % b;
        end
    endfunction

    vec_t vecs[14];

    initial begin
        logic [N-1:0] q, r, qa, last_q, rq, rr;
        logic dbz, ovf, da, rdbz, rovf, saw_done;
        int lat;

        vecs[0]  = '{1'b0, 32'd90210,      32'd234,        32'd385,        32'd120,        1'b0, 1'b0, NORM_LAT};
        vecs[1]  = '{1'b1, 32'd17,         32'd5,          32'd3,          32'd2,          1'b0, 1'b0, NORM_LAT};
        vecs[2]  = '{1'b1, 32'd17,         32'hFFFF_FFFB,  32'hFFFF_FFFD,  32'd2,          1'b0, 1'b0, NORM_LAT};
        vecs[3]  = '{1'b1, 32'hFFFF_FFEF,  32'd5,          32'hFFFF_FFFD,  32'hFFFF_FFFE,  1'b0, 1'b0, NORM_LAT};
        vecs[4]  = '{1'b1, 32'hFFFF_FFEF,  32'hFFFF_FFFB,  32'd3,          32'hFFFF_FFFE,  1'b0, 1'b0, NORM_LAT};
        vecs[5]  = '{1'b0, 32'd666,        32'd0,          32'hFFFF_FFFF,  32'd666,        1'b1, 1'b0, 0};
        vecs[6]  = '{1'b1, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFF9,  1'b1, 1'b0, 0};
        vecs[7]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0, 1'b1, 0};
        vecs[8]  = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  1'b0, 1'b0, NORM_LAT};
        vecs[9]  = '{1'b0, 32'd0,          32'd7,          32'd0,          32'd0,          1'b0, 1'b0, NORM_LAT};
        vecs[10] = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0, 1'b0, NORM_LAT};
        vecs[11] = '{1'b1, 32'h8000_0000,  32'd2,          32'hC000_0000,  32'd0,          1'b0, 1'b0, NORM_LAT};
        vecs[12] = '{1'b0, 32'd7,          32'hFFFF_FFFF,  32'd0,          32'd7,          1'b0, 1'b0, NORM_LAT};
        vecs[13] = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 1'b0, NORM_LAT};

        // Reset state.
        repeat (3) @(posedge clk_100);
        #1;
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_outputs", {quotient, remainder}, 64'd0);
        check("reset_errs", {62'd0, div_by_0_err, overflow_err}, 64'd0);
        @(negedge clk_100);
        reset = 1'b0;

        // Directed table.
        for (int i = 0; i < 14; i++) begin
            run_op(vecs[i].s, vecs[i].a, vecs[i].b, q, r, dbz, ovf, lat, da, qa);
            check($sformatf("v%0d_quotient", i), {32'd0, q}, {32'd0, vecs[i].q});
            check($sformatf("v%0d_remainder", i), {32'd0, r}, {32'd0, vecs[i].r});
            check($sformatf("v%0d_errs", i), {62'd0, dbz, ovf}, {62'd0, vecs[i].dbz, vecs[i].ovf});
            check($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
            check($sformatf("v%0d_done_drop", i), {63'd0, da}, 64'd0);
            check($sformatf("v%0d_hold", i), {32'd0, qa}, {32'd0, vecs[i].q});
        end
        last_q = vecs[13].q;

        // Abort at iteration 10: no done, outputs unchanged.
        @(negedge clk_100);
        is_signed = 1'b0; dividend = 32'hFFFF_FFFF; divisor = 32'd3; start = 1'b1;
        repeat (11) @(posedge clk_100);
        @(negedge clk_100);
        start = 1'b0;
        saw_done = 1'b0;
        repeat (40) begin
            @(posedge clk_100);
            #1;
            saw_done |= done;
        end
        check("abort_no_done", {63'd0, saw_done}, 64'd0);
        check("abort_hold_q", {32'd0, quotient}, {32'd0, last_q});
        run_op(1'b0, 32'd9, 32'd3, q, r, dbz, ovf, lat, da, qa);
        check("after_abort_q", {32'd0, q}, 64'd3);
        check("after_abort_r", {32'd0, r}, 64'd0);
        check("after_abort_lat", 64'(lat), 64'(NORM_LAT));

        // Reset mid-operation clears everything on the next edge.
        @(negedge clk_100);
        is_signed = 1'b0; dividend = 32'd1000; divisor = 32'd7; start = 1'b1;
        repeat (6) @(posedge clk_100);
        @(negedge clk_100);
        reset = 1'b1;
        @(posedge clk_100);
        #1;
        check("midreset_done", {63'd0, done}, 64'd0);
        check("midreset_outputs", {quotient, remainder}, 64'd0);
        @(negedge clk_100);
        start = 1'b0;
        @(negedge clk_100);
        reset = 1'b0;
        repeat (2) @(posedge clk_100);

        // Randomized sweep against the reference model.
        for (int k = 0; k < 300; k++) begin
            logic s;
            logic [N-1:0] a, b;
            s = k[0];
            a = $urandom;
            b = $urandom;
            case (k % 10)
                3: b = 32'd0;
                4: b = 32'($urandom_range(1, 15));
                5: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                6: b = 32'hFFFF_FFFF;
                7: a = 32'($urandom_range(0, 100));
                default: ;
            endcase
            ref_div(s, a, b, rq, rr, rdbz, rovf);
            run_op(s, a, b, q, r, dbz, ovf, lat, da, qa);
            check($sformatf("rnd%0d_q s=%0d %h/%h", k, s, a, b), {32'd0, q}, {32'd0, rq});
            check($sformatf("rnd%0d_r s=%0d %h/%h", k, s, a, b), {32'd0, r}, {32'd0, rr});
            check($sformatf("rnd%0d_errs", k), {62'd0, dbz, ovf}, {62'd0, rdbz, rovf});
            check($sformatf("rnd%0d_lat", k), 64'(lat), (rdbz || rovf) ? 64'd0 : 64'(NORM_LAT));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
